// File: rtl/fx_arith_unit.sv
// fx_arith_unit: handshaked signed fixed-point ADD/SUB/MUL/DIV on Q(NBITS-FRAC).FRAC operands.
// ADD, SUB, MUL and divide-by-zero complete on the accept edge; DIV uses a
// restoring divider producing one quotient bit per cycle.
// Optional build macro FX_ARITH_SAT_EN: out-of-range results saturate instead of wrapping.
module fx_arith_unit #(
  parameter int NBITS = 16,
  parameter int FRAC  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] xout,
  output logic             ovf,
  output logic             divz
);

  // Divider working width: dividend |A|<<FRAC plus one spare bit.
  localparam int W  = NBITS + FRAC + 1;
  // Full-precision signed width, wide enough for every intermediate result.
  localparam int FW = 2 * NBITS + 2;
  localparam int CW = $clog2(NBITS + FRAC + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(NBITS + FRAC - 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DIV_ITER = 2'd1;
  localparam logic [1:0] DONE     = 2'd2;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  localparam logic signed [FW-1:0] MAX_FULL = {{(FW-NBITS+1){1'b0}}, {(NBITS-1){1'b1}}};
  localparam logic signed [FW-1:0] MIN_FULL = {{(FW-NBITS+1){1'b1}}, {(NBITS-1){1'b0}}};
  localparam logic [NBITS-1:0] MAX_X = {1'b0, {(NBITS-1){1'b1}}};
  localparam logic [NBITS-1:0] MIN_X = {1'b1, {(NBITS-1){1'b0}}};

  logic [1:0]       state_reg;
  logic [NBITS-1:0] xout_reg;
  logic             ovf_reg;
  logic             divz_reg;
  logic [CW-1:0]    cnt_reg;
  logic [W-1:0]     rem_reg;
  logic [W-1:0]     quo_reg;
  logic [W-1:0]     divisor_reg;
  logic             sign_reg;

  logic signed [FW-1:0] a_ext;
  logic signed [FW-1:0] b_ext;
  logic signed [FW-1:0] imm_full;
  logic [NBITS-1:0]     mag_a;
  logic [NBITS-1:0]     mag_b;
  logic                 div_start;

  logic [W-1:0]         rem_shift;
  logic                 rem_ge;
  logic [W-1:0]         rem_next;
  logic [W-1:0]         quo_next;
  logic [FW-1:0]        q_ext;
  logic signed [FW-1:0] div_full;

  logic [NBITS:0]       imm_fit;
  logic [NBITS:0]       div_fit;

  // Range check of a full-precision value; returns {ovf, result}.
  function automatic logic [NBITS:0] fit(input logic signed [FW-1:0] v);
    logic             ov;
    logic [NBITS-1:0] x;
    ov = (v > MAX_FULL) || (v < MIN_FULL);
    x  = v[NBITS-1:0];
`ifdef FX_ARITH_SAT_EN
    if (ov) x = v[FW-1] ? MIN_X : MAX_X;
`endif
    return {ov, x};
  endfunction

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign xout      = xout_reg;
  assign ovf       = ovf_reg;
  assign divz      = divz_reg;

  assign a_ext = {{(FW-NBITS){a[NBITS-1]}}, a};
  assign b_ext = {{(FW-NBITS){b[NBITS-1]}}, b};

  // Magnitudes as unsigned NBITS values: the most-negative input maps to 2^(NBITS-1) exactly.
  assign mag_a = a[NBITS-1] ? (-a) : a;
  assign mag_b = b[NBITS-1] ? (-b) : b;

  assign div_start = (op == OP_DIV) && (b != '0);

  // Single-cycle result for ADD/SUB/MUL and divide-by-zero, from the live inputs.
  always_comb begin
    imm_full = '0;
    case (op)
      OP_ADD: imm_full = a_ext + b_ext;
      OP_SUB: imm_full = a_ext - b_ext;
      OP_MUL: imm_full = (a_ext * b_ext) >>> FRAC;
      default: begin
        if (a[NBITS-1])   imm_full = MIN_FULL;
        else if (a != '0) imm_full = MAX_FULL;
        else              imm_full = '0;
      end
    endcase
  end

  assign imm_fit = fit(imm_full);

  // One restoring-division step; the bit shifted out of rem_reg counts as "big enough".
  always_comb begin
    rem_shift = {rem_reg[W-2:0], quo_reg[W-1]};
    rem_ge    = rem_reg[W-1] || (rem_shift >= divisor_reg);
    rem_next  = rem_ge ? (rem_shift - divisor_reg) : rem_shift;
    quo_next  = {quo_reg[W-2:0], rem_ge};
    q_ext     = {{(FW-W){1'b0}}, quo_next};
    div_full  = sign_reg ? -$signed(q_ext) : $signed(q_ext);
  end

  assign div_fit = fit(div_full);

  // Control FSM, divider datapath and registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      xout_reg    <= '0;
      ovf_reg     <= 1'b0;
      divz_reg    <= 1'b0;
      cnt_reg     <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      divisor_reg <= '0;
      sign_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            if (div_start) begin
              // Dividend |A|<<FRAC is pre-aligned one place up: its top bit is always zero.
              sign_reg    <= a[NBITS-1] ^ b[NBITS-1];
              quo_reg     <= {mag_a, {(FRAC+1){1'b0}}};
              divisor_reg <= {{(FRAC+1){1'b0}}, mag_b};
              rem_reg     <= '0;
              cnt_reg     <= '0;
              state_reg   <= DIV_ITER;
            end else begin
              xout_reg  <= imm_fit[NBITS-1:0];
              ovf_reg   <= imm_fit[NBITS] && (op != OP_DIV);
              divz_reg  <= (op == OP_DIV);
              state_reg <= DONE;
            end
          end
        end
        DIV_ITER: begin
          rem_reg <= rem_next;
          quo_reg <= quo_next;
          if (cnt_reg == LAST_ITER) begin
            cnt_reg   <= '0;
            xout_reg  <= div_fit[NBITS-1:0];
            ovf_reg   <= div_fit[NBITS];
            divz_reg  <= 1'b0;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fx_arith_unit.sv
// tb_fx_arith_unit: randomized and directed checks of fx_arith_unit against an
// arithmetic reference model (NBITS=16, FRAC=8). Honours FX_ARITH_SAT_EN like the design.
module tb_fx_arith_unit;

  localparam int NB = 16;
  localparam int FR = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    op = 2'd0;
  logic [NB-1:0] a = '0;
  logic [NB-1:0] b = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [NB-1:0] xout;
  logic          ovf;
  logic          divz;

  int checks = 0;
  int errors = 0;

  fx_arith_unit #(.NBITS(NB), .FRAC(FR)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .xout(xout), .ovf(ovf), .divz(divz)
  );

  always #5 clk = ~clk;

  // Reference: exact integer arithmetic on the real values scaled by 2^FR.
  function automatic void model(input logic [1:0] o, input logic [NB-1:0] aa, input logic [NB-1:0] bb,
                                output logic [NB-1:0] x, output logic ov, output logic dz, output int lat);
    longint av, bv, v, p, hi, lo;
    av = longint'($signed(aa));
    bv = longint'($signed(bb));
    hi = (longint'(1) << (NB-1)) - 1;
    lo = -(longint'(1) << (NB-1));
    dz = 1'b0;
    lat = 1;
    v = 0;
    case (o)
      2'd0: v = av + bv;
      2'd1: v = av - bv;
      2'd2: begin
        p = av * bv;
        v = p / (longint'(1) << FR);
        if (p < 0 && (p % (longint'(1) << FR)) != 0) v = v - 1;
      end
      default: begin
        if (bv == 0) begin
          dz = 1'b1;
          v = (av > 0) ? hi : ((av < 0) ? lo : 0);
        end else begin
          v = (av * (longint'(1) << FR)) / bv;
          lat = NB + FR + 1;
        end
      end
    endcase
    ov = (v > hi) || (v < lo);
    x = v[NB-1:0];
`ifdef FX_ARITH_SAT_EN
    if (ov) x = (v > 0) ? hi[NB-1:0] : lo[NB-1:0];
`endif
  endfunction

  // Operand generator biased toward boundary values.
  function automatic logic [NB-1:0] pick();
    int r;
    logic [NB-1:0] s;
    r = $urandom_range(0, 9);
    case (r)
      0: s = 16'h8000;
      1: s = 16'h7FFF;
      2: s = 16'h0000;
      3: begin
        s = NB'($urandom_range(0, 1023));
        if ($urandom_range(0, 1) == 1) s = -s;
      end
      default: s = NB'($urandom);
    endcase
    return s;
  endfunction

  // Drives one transaction with out_ready high and returns what the DUT produced.
  task automatic run_txn(input logic [1:0] o, input logic [NB-1:0] aa, input logic [NB-1:0] bb,
                         output logic [NB-1:0] x, output logic ov, output logic dz,
                         output int lat, output bit busy_ok);
    int k;
    @(negedge clk);
    op = o; a = aa; b = bb; in_valid = 1'b1; out_ready = 1'b1;
    k = 0;
    while (in_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = NB'($urandom); b = NB'($urandom); op = 2'($urandom);
    lat = -1;
    busy_ok = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        lat = c;
        break;
      end
      if (in_ready !== 1'b0) busy_ok = 1'b0;
    end
    x = xout; ov = ovf; dz = divz;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
    checks++; if (xout !== '0)        begin errors++; $display("FAIL reset_xout got %h expected 0000", xout); end
    checks++; if (ovf !== 1'b0)       begin errors++; $display("FAIL reset_ovf got %b expected 0", ovf); end
    checks++; if (divz !== 1'b0)      begin errors++; $display("FAIL reset_divz got %b expected 0", divz); end
    @(negedge clk);
    rst = 1'b0;
    $display("reset: released");
  endtask

  task automatic test_directed();
    logic [1:0]    vo [8] = '{2'd0, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd3, 2'd3};
    logic [NB-1:0] va [8] = '{16'h0180, 16'h0180, 16'hFE80, 16'h0300, 16'hFD00, 16'h7F00, 16'hFF00, 16'h0000};
    logic [NB-1:0] vb [8] = '{16'h0240, 16'h0240, 16'h0240, 16'h0180, 16'h0200, 16'h0200, 16'h0000, 16'h0000};
`ifdef FX_ARITH_SAT_EN
    logic [NB-1:0] vx [8] = '{16'h03C0, 16'h0360, 16'hFCA0, 16'h0200, 16'hFE80, 16'h7FFF, 16'h8000, 16'h0000};
`else
    logic [NB-1:0] vx [8] = '{16'h03C0, 16'h0360, 16'hFCA0, 16'h0200, 16'hFE80, 16'h8100, 16'h8000, 16'h0000};
`endif
    logic          vv [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic          vz [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int            vl [8] = '{1, 1, 1, 25, 25, 1, 1, 1};
    logic [NB-1:0] x;
    logic          ov, dz;
    int            lat;
    bit            busy_ok;
    for (int i = 0; i < 8; i++) begin
      run_txn(vo[i], va[i], vb[i], x, ov, dz, lat, busy_ok);
      $display("directed %0d: op=%0d a=%h b=%h -> x=%h ovf=%b divz=%b lat=%0d", i, vo[i], va[i], vb[i], x, ov, dz, lat);
      checks++; if (x !== vx[i])   begin errors++; $display("FAIL directed_xout[%0d] got %h expected %h", i, x, vx[i]); end
      checks++; if (ov !== vv[i])  begin errors++; $display("FAIL directed_ovf[%0d] got %b expected %b", i, ov, vv[i]); end
      checks++; if (dz !== vz[i])  begin errors++; $display("FAIL directed_divz[%0d] got %b expected %b", i, dz, vz[i]); end
      checks++; if (lat !== vl[i]) begin errors++; $display("FAIL directed_latency[%0d] got %0d expected %0d", i, lat, vl[i]); end
      checks++; if (!busy_ok)      begin errors++; $display("FAIL directed_in_ready_busy[%0d] got in_ready high while busy expected low", i); end
    end
  endtask

  task automatic test_random();
    logic [1:0]    o;
    logic [NB-1:0] aa, bb, x, ex;
    logic          ov, dz, eov, edz;
    int            lat, elat;
    bit            busy_ok;
    for (int i = 0; i < 250; i++) begin
      o = 2'($urandom_range(0, 3));
      aa = pick();
      bb = pick();
      model(o, aa, bb, ex, eov, edz, elat);
      run_txn(o, aa, bb, x, ov, dz, lat, busy_ok);
      $display("random %0d: op=%0d a=%h b=%h -> x=%h ovf=%b divz=%b lat=%0d", i, o, aa, bb, x, ov, dz, lat);
      checks++; if (x !== ex)     begin errors++; $display("FAIL random_xout[%0d] got %h expected %h", i, x, ex); end
      checks++; if (ov !== eov)   begin errors++; $display("FAIL random_ovf[%0d] got %b expected %b", i, ov, eov); end
      checks++; if (dz !== edz)   begin errors++; $display("FAIL random_divz[%0d] got %b expected %b", i, dz, edz); end
      checks++; if (lat !== elat) begin errors++; $display("FAIL random_latency[%0d] got %0d expected %0d", i, lat, elat); end
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
        begin errors++; $display("FAIL random_release[%0d] got out_valid=%b in_ready=%b expected 0/1", i, out_valid, in_ready); end
    end
  endtask

  task automatic test_backpressure();
    logic [NB-1:0] aa, bb, ex;
    logic          eov, edz;
    int            elat;
    aa = NB'($urandom);
    bb = NB'($urandom);
    model(2'd0, aa, bb, ex, eov, edz, elat);
    @(negedge clk);
    op = 2'd0; a = aa; b = bb; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      $display("stall %0d: out_valid=%b in_ready=%b x=%h ovf=%b divz=%b", i, out_valid, in_ready, xout, ovf, divz);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid[%0d] got %b expected 1", i, out_valid); end
      checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL stall_in_ready[%0d] got %b expected 0", i, in_ready); end
      checks++; if (xout !== ex)        begin errors++; $display("FAIL stall_xout[%0d] got %h expected %h", i, xout, ex); end
      checks++; if (ovf !== eov || divz !== 1'b0)
        begin errors++; $display("FAIL stall_flags[%0d] got ovf=%b divz=%b expected %b/0", i, ovf, divz, eov); end
      // Pulse new operands while stalled; they must not be taken.
      in_valid = (i % 2 == 0);
      a = NB'($urandom); b = NB'($urandom); op = 2'($urandom);
      if (i == 4) begin
        in_valid = 1'b0;
        out_ready = 1'b1;
      end
    end
    @(negedge clk);
    $display("stall release: out_valid=%b in_ready=%b", out_valid, in_ready);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_out_valid got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL release_in_ready got %b expected 1", in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_no_ghost got out_valid=%b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid_div();
    logic [NB-1:0] aa, bb, x, ex;
    logic          ov, dz, eov, edz;
    int            lat, elat;
    bit            busy_ok;
    @(negedge clk);
    op = 2'd3; a = 16'h0300; b = 16'h0180; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    $display("mid-div reset: out_valid=%b in_ready=%b x=%h ovf=%b divz=%b", out_valid, in_ready, xout, ovf, divz);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL abort_in_ready got %b expected 1", in_ready); end
    checks++; if (xout !== '0)        begin errors++; $display("FAIL abort_xout got %h expected 0000", xout); end
    checks++; if (ovf !== 1'b0 || divz !== 1'b0)
      begin errors++; $display("FAIL abort_flags got ovf=%b divz=%b expected 0/0", ovf, divz); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_stale_valid[%0d] got %b expected 0", i, out_valid); end
    end
    aa = NB'($urandom);
    bb = NB'($urandom);
    model(2'd0, aa, bb, ex, eov, edz, elat);
    run_txn(2'd0, aa, bb, x, ov, dz, lat, busy_ok);
    $display("post-reset add: a=%h b=%h -> x=%h ovf=%b lat=%0d", aa, bb, x, ov, lat);
    checks++; if (x !== ex)     begin errors++; $display("FAIL post_reset_xout got %h expected %h", x, ex); end
    checks++; if (ov !== eov || dz !== 1'b0)
      begin errors++; $display("FAIL post_reset_flags got ovf=%b divz=%b expected %b/0", ov, dz, eov); end
    checks++; if (lat !== elat) begin errors++; $display("FAIL post_reset_latency got %0d expected %0d", lat, elat); end
  endtask

  task automatic test_back_to_back();
    int first_accept, second_accept, cyc;
    cyc = 0;
    first_accept = -1;
    second_accept = -1;
    @(negedge clk);
    op = 2'd1; a = 16'h0100; b = 16'h0080; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      if (in_ready === 1'b1) begin
        if (first_accept < 0) first_accept = cyc;
        else if (second_accept < 0) second_accept = cyc;
      end
      cyc++;
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    $display("back-to-back: accepts at %0d and %0d", first_accept, second_accept);
    checks++; if (second_accept - first_accept !== 2)
      begin errors++; $display("FAIL back_to_back_period got %0d expected 2", second_accept - first_accept); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_div();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
